stream_rr_arb: RTL and testbench
================================

// Module: stream_rr_arb
// PURPOSE
//  N-to-1 valid/ready stream arbiter: shares one downstream consumer among NUM_REQ requesters.
//  Round-robin grant, one registered output stage, so 1-cycle latency at full throughput.
//  Companion to the stream fork: fork fans a stream out, this block merges streams back in.
//  m_sel tells downstream logic which source produced each beat.
// PARAMETERS
//  DATA_BW   8   payload width per requester
//  NUM_REQ   4   number of requesters, >=2, need not be a power of 2
//  SEL_BW    $clog2(NUM_REQ)   localparam, width of index signals
// PORTS
//  clk      in   1                clock, all logic rising-edge
//  rst      in   1                reset, asynchronous, active-high
//  s_valid  in   NUM_REQ          per-requester valid
//  s_data   in   NUM_REQ*DATA_BW  requester i payload at [i*DATA_BW +: DATA_BW]
//  s_ready  out  NUM_REQ          per-requester ready, at most one bit high
//  m_valid  out  1                output valid (registered)
//  m_data   out  DATA_BW          output payload (registered)
//  m_sel    out  SEL_BW           index of the source of the current m_data (registered)
//  m_ready  in   1                downstream ready
// BEHAVIOUR
//  Reset (async, while rst=1): m_valid=0, m_data=0, m_sel=0, rr pointer ptr=0, lock=0.
//   s_ready is all-zero throughout reset.
//  can_load = !m_valid || m_ready. This gives a 1-entry pipeline stage with no bubble on back-to-back beats.
//  Grant is combinational, recomputed each cycle:
//   - Pick the first i with s_valid[i]=1, scanning ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1.
//  s_ready[grant] = can_load && any s_valid; all other s_ready bits are 0.
//  s_ready never depends combinationally on the same requester's s_valid beyond grant selection.
//  Accept (s_valid[g] && s_ready[g]) at edge:
//   - m_valid<=1, m_data<=s_data[g], m_sel<=g.
//   - ptr<=(g==NUM_REQ-1)?0:g+1.
//  m_ready && m_valid with no accept: m_valid<=0. m_data and m_sel hold their last values.
//  m_valid && !m_ready: m_valid, m_data and m_sel are held stable. No requester sees s_ready.
//  Simultaneous requests: the requester nearest ptr wins. Every steadily requesting source is served within NUM_REQ beats.
//  Non-power-of-2 NUM_REQ: ptr wraps from NUM_REQ-1 to 0, never reaches out-of-range values.
//  Requester dropping s_valid before acceptance is a protocol violation. Block behaviour stays defined: grant simply moves on.
//  Reset mid-transfer: the in-flight beat is discarded (m_valid=0). Arbitration restarts from requester 0.
// CONFIGURATION
//  STREAM_ARB_PKT_EN defined: packet mode.
//   - Adds ports s_last [NUM_REQ] in and m_last [1] out (registered, reset 0).
//   - Accepting a beat with s_last[g]=0 sets lock=1 and lk_idx=g. Only lk_idx is eligible while locked.
//   - Accepting a beat with s_last=1 clears lock. ptr updates only on this last beat.
//   - m_last <= s_last[g] on accept.
//  STREAM_ARB_PKT_EN undefined: no last ports, no lock; arbitration happens per beat.
// TESTING
//  1. rst pulse mid-stream with m_valid=1 -> m_valid=0, s_ready=0 asynchronously; first grant after release goes to req0.
//  2. Only req2 valid, m_ready=1, data 0x11,0x22,0x33 -> m_data the same values 1 cycle later, m_sel=2, no bubbles.
//  3. All 4 valid, m_ready=1 -> m_sel sequence 0,1,2,3,0,1 on consecutive cycles.
//  4. m_ready=0 for 5 cycles with m_valid=1 -> m_data/m_sel stable, s_ready=0; on release, the next beat follows the next cycle.
//  5. NUM_REQ=3, req2 then req0,req1 valid -> ptr wraps, m_sel 2,0,1.
//  6. PKT_EN: req0 sends 3-beat packet (last on beat 3) while req1 valid -> m_sel 0,0,0,1 and m_last 0,0,1,x.

Source files
------------

// File: rtl/stream_rr_arb_if.sv
// Stream bundle for stream_rr_arb: NUM_REQ requester streams in, one merged stream out.
// Packet signals s_last/m_last exist only when STREAM_ARB_PKT_EN is defined.
interface stream_rr_arb_if #(
  parameter int DATA_BW = 8,
  parameter int NUM_REQ = 4
);
  localparam int SEL_BW = $clog2(NUM_REQ);

  // Valid/ready: a beat transfers on a rising edge where valid and ready are both 1.
  // A source holds valid and payload stable until that edge; ready may change freely.
  logic [NUM_REQ-1:0]         s_valid;
  logic [NUM_REQ-1:0]         s_ready;
  logic [NUM_REQ*DATA_BW-1:0] s_data;
  logic                       m_valid;
  logic                       m_ready;
  logic [DATA_BW-1:0]         m_data;
  logic [SEL_BW-1:0]          m_sel;
`ifdef STREAM_ARB_PKT_EN
  logic [NUM_REQ-1:0]         s_last;
  logic                       m_last;

  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_data, m_sel, m_last);
  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_data, m_sel, m_last);
`else
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data, m_sel);
  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data, m_sel);
`endif
endinterface

// File: rtl/stream_rr_arb.sv
// N-to-1 round-robin valid/ready stream arbiter with one registered output stage.
// Define STREAM_ARB_PKT_EN for packet mode (grant locked to one source until s_last).
module stream_rr_arb #(
  parameter int DATA_BW = 8,
  parameter int NUM_REQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  stream_rr_arb_if.slave  bus
);
  localparam int SEL_BW = $clog2(NUM_REQ);

  logic               r_m_valid;
  logic [DATA_BW-1:0] r_m_data;
  logic [SEL_BW-1:0]  r_m_sel;
  logic [SEL_BW-1:0]  r_ptr;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [SEL_BW-1:0]  w_grant;
  logic               w_can_load;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_ready;
  logic [SEL_BW-1:0]  w_next_ptr;
  logic [DATA_BW-1:0] w_grant_data;

`ifdef STREAM_ARB_PKT_EN
  logic               r_lock;
  logic [SEL_BW-1:0]  r_lk_idx;
  logic               r_m_last;
  logic [NUM_REQ-1:0] w_lk_mask;
  logic               w_grant_last;

  always_comb begin
    w_lk_mask = '0;
    w_lk_mask[r_lk_idx] = 1'b1;
    w_elig = r_lock ? (bus.s_valid & w_lk_mask) : bus.s_valid;
  end

  assign w_grant_last = bus.s_last[w_grant];
  assign bus.m_last   = r_m_last;
`else
  assign w_elig = bus.s_valid;
`endif

  // Scan ptr, ptr+1, ..., wrapping at NUM_REQ so non-power-of-2 counts stay in range.
  always_comb begin : grant_search
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_grant = SEL_BW'(idx);
      end
    end
  end

  assign w_can_load   = !r_m_valid || bus.m_ready;
  assign w_accept     = w_can_load && w_found && !rst;
  assign w_next_ptr   = (w_grant == SEL_BW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
  assign w_grant_data = bus.s_data[int'(w_grant)*DATA_BW +: DATA_BW];

  always_comb begin
    w_ready = '0;
    if (w_accept) w_ready[w_grant] = 1'b1;
  end

  assign bus.s_ready = w_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_sel   = r_m_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_sel   <= '0;
      r_ptr     <= '0;
`ifdef STREAM_ARB_PKT_EN
      r_lock    <= 1'b0;
      r_lk_idx  <= '0;
      r_m_last  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_grant_data;
      r_m_sel   <= w_grant;
`ifdef STREAM_ARB_PKT_EN
      r_m_last  <= w_grant_last;
      r_lock    <= !w_grant_last;
      r_lk_idx  <= w_grant;
      // Fairness advances per packet, not per beat.
      if (w_grant_last) r_ptr <= w_next_ptr;
`else
      r_ptr     <= w_next_ptr;
`endif
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_rr_arb.sv
// Directed bench for stream_rr_arb: a 4-requester and a 3-requester instance,
// queue-fed source drivers, and per-instance scoreboards checked by output monitors.
module tb_stream_rr_arb;
  localparam int W = 11;  // {last, sel[1:0], data[7:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_rr_arb_if #(.DATA_BW(8), .NUM_REQ(4)) bus4 ();
  stream_rr_arb_if #(.DATA_BW(8), .NUM_REQ(3)) bus3 ();

  stream_rr_arb #(.DATA_BW(8), .NUM_REQ(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  stream_rr_arb #(.DATA_BW(8), .NUM_REQ(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp4_q[$];
  logic [W-1:0] exp3_q[$];
  logic [8:0]   src4_q[4][$];
  logic [8:0]   src3_q[3][$];
  logic [3:0]   fire4;
  logic [2:0]   fire3;

  function automatic logic [W-1:0] ew(input logic last, input logic [1:0] sel, input logic [7:0] d);
    return {last, sel, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push4(input int i, input logic [7:0] d, input logic last);
    src4_q[i].push_back({last, d});
  endtask

  task automatic push3(input int i, input logic [7:0] d, input logic last);
    src3_q[i].push_back({last, d});
  endtask

  task automatic wait_valid4();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus4.m_valid;
    end
    check("wait_m_valid", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((exp4_q.size() != 0 || exp3_q.size() != 0) && c < 60) begin
      @(negedge clk);
      c++;
    end
    check("drain_timeout", exp4_q.size() + exp3_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Source drivers: handshake seen at negedge, next beat presented just after the edge.
  always @(negedge clk) begin
    fire4 = bus4.s_valid & bus4.s_ready;
    fire3 = bus3.s_valid & bus3.s_ready;
  end

  always @(posedge clk) begin
    logic [3:0]  v4;
    logic [31:0] d4;
    logic [2:0]  v3;
    logic [23:0] d3;
`ifdef STREAM_ARB_PKT_EN
    logic [3:0]  l4;
    logic [2:0]  l3;
`endif
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire4[i] && !rst && src4_q[i].size() > 0) void'(src4_q[i].pop_front());
      v4[i] = src4_q[i].size() > 0;
      d4[i*8 +: 8] = v4[i] ? src4_q[i][0][7:0] : 8'h00;
`ifdef STREAM_ARB_PKT_EN
      l4[i] = v4[i] ? src4_q[i][0][8] : 1'b0;
`endif
    end
    for (int i = 0; i < 3; i++) begin
      if (fire3[i] && !rst && src3_q[i].size() > 0) void'(src3_q[i].pop_front());
      v3[i] = src3_q[i].size() > 0;
      d3[i*8 +: 8] = v3[i] ? src3_q[i][0][7:0] : 8'h00;
`ifdef STREAM_ARB_PKT_EN
      l3[i] = v3[i] ? src3_q[i][0][8] : 1'b0;
`endif
    end
    bus4.s_valid = v4;
    bus4.s_data  = d4;
    bus3.s_valid = v3;
    bus3.s_data  = d3;
`ifdef STREAM_ARB_PKT_EN
    bus4.s_last  = l4;
    bus3.s_last  = l3;
`endif
  end

  // Output monitors: every transferred beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    logic [W-1:0] act4, act3;
`ifdef STREAM_ARB_PKT_EN
    act4 = {bus4.m_last, bus4.m_sel, bus4.m_data};
    act3 = {bus3.m_last, bus3.m_sel, bus3.m_data};
`else
    act4 = {1'b1, bus4.m_sel, bus4.m_data};
    act3 = {1'b1, bus3.m_sel, bus3.m_data};
`endif
    if (!rst && bus4.m_valid && bus4.m_ready) begin
      if (exp4_q.size() == 0) check("dut4_unexpected_beat", {21'd0, act4}, 32'hFFFF_FFFF);
      else check("dut4_beat", {21'd0, act4}, {21'd0, exp4_q.pop_front()});
    end
    if (!rst && bus3.m_valid && bus3.m_ready) begin
      if (exp3_q.size() == 0) check("dut3_unexpected_beat", {21'd0, act3}, 32'hFFFF_FFFF);
      else check("dut3_beat", {21'd0, act3}, {21'd0, exp3_q.pop_front()});
    end
  end

  initial begin
    bus4.s_valid = '0; bus4.s_data = '0; bus4.m_ready = 1'b1;
    bus3.s_valid = '0; bus3.s_data = '0; bus3.m_ready = 1'b1;
`ifdef STREAM_ARB_PKT_EN
    bus4.s_last = '0; bus3.s_last = '0;
`endif

    // Reset state, with a request already pending: no ready may be given.
    push4(1, 8'h5A, 1'b1); exp4_q.push_back(ew(1'b1, 2'd1, 8'h5A));
    repeat (3) @(negedge clk);
    check("rst_m_valid", {31'd0, bus4.m_valid}, 0);
    check("rst_m_data",  {24'd0, bus4.m_data}, 0);
    check("rst_m_sel",   {30'd0, bus4.m_sel}, 0);
    check("rst_s_ready", {28'd0, bus4.s_ready}, 0);
    check("rst_s_valid_seen", {28'd0, bus4.s_valid}, 32'h2);
    check("rst3_m_valid", {31'd0, bus3.m_valid}, 0);
`ifdef STREAM_ARB_PKT_EN
    check("rst_m_last", {31'd0, bus4.m_last}, 0);
`endif
    @(posedge clk); #3 rst = 1'b0;
    wait_idle();

    // Single source req2, three beats back to back with no bubble.
    push4(2, 8'h11, 1'b1); push4(2, 8'h22, 1'b1); push4(2, 8'h33, 1'b1);
    exp4_q.push_back(ew(1'b1, 2'd2, 8'h11));
    exp4_q.push_back(ew(1'b1, 2'd2, 8'h22));
    exp4_q.push_back(ew(1'b1, 2'd2, 8'h33));
    wait_valid4();
    @(negedge clk); check("req2_beat2_valid", {31'd0, bus4.m_valid}, 1);
    @(negedge clk); check("req2_beat3_valid", {31'd0, bus4.m_valid}, 1);
    @(negedge clk); check("req2_after_idle", {31'd0, bus4.m_valid}, 0);
    wait_idle();

    // Backpressure: ptr=3 so req3 wins; output frozen while m_ready=0.
    @(posedge clk); #1 bus4.m_ready = 1'b0;
    push4(0, 8'h44, 1'b1); push4(3, 8'h55, 1'b1);
    exp4_q.push_back(ew(1'b1, 2'd3, 8'h55));
    exp4_q.push_back(ew(1'b1, 2'd0, 8'h44));
    wait_valid4();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_m_valid", {31'd0, bus4.m_valid}, 1);
      check("stall_m_data",  {24'd0, bus4.m_data}, 32'h55);
      check("stall_m_sel",   {30'd0, bus4.m_sel}, 3);
      check("stall_s_ready", {28'd0, bus4.s_ready}, 0);
    end
    @(posedge clk); #1 bus4.m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_next_valid", {31'd0, bus4.m_valid}, 1);
    check("release_next_data",  {24'd0, bus4.m_data}, 32'h44);
    wait_idle();

    // Reset mid-transfer: in-flight req1 beat dropped, arbitration restarts at req0.
    @(posedge clk); #1 bus4.m_ready = 1'b0;
    push4(1, 8'h61, 1'b1); push4(1, 8'h62, 1'b1); push4(3, 8'h63, 1'b1);
    wait_valid4();
    check("inflight_sel",  {30'd0, bus4.m_sel}, 1);
    check("inflight_data", {24'd0, bus4.m_data}, 32'h61);
    @(negedge clk); #2 rst = 1'b1;
    push4(0, 8'h60, 1'b1);
    #1;
    check("async_rst_m_valid", {31'd0, bus4.m_valid}, 0);
    check("async_rst_s_ready", {28'd0, bus4.s_ready}, 0);
    bus4.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hold_s_ready", {28'd0, bus4.s_ready}, 0);
    exp4_q.push_back(ew(1'b1, 2'd0, 8'h60));
    exp4_q.push_back(ew(1'b1, 2'd1, 8'h62));
    exp4_q.push_back(ew(1'b1, 2'd3, 8'h63));
    @(posedge clk); #3 rst = 1'b0;
    wait_idle();

    // All four requesting from ptr=0: sel 0,1,2,3,0,1 on consecutive cycles.
    push4(0, 8'hA0, 1'b1); push4(0, 8'hA1, 1'b1);
    push4(1, 8'hB0, 1'b1); push4(1, 8'hB1, 1'b1);
    push4(2, 8'hC0, 1'b1); push4(3, 8'hD0, 1'b1);
    exp4_q.push_back(ew(1'b1, 2'd0, 8'hA0));
    exp4_q.push_back(ew(1'b1, 2'd1, 8'hB0));
    exp4_q.push_back(ew(1'b1, 2'd2, 8'hC0));
    exp4_q.push_back(ew(1'b1, 2'd3, 8'hD0));
    exp4_q.push_back(ew(1'b1, 2'd0, 8'hA1));
    exp4_q.push_back(ew(1'b1, 2'd1, 8'hB1));
    wait_valid4();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rr_no_bubble", {31'd0, bus4.m_valid}, 1);
    end
    wait_idle();

    // NUM_REQ=3: req2 first, then req0/req1, then all three after the wrap.
    push3(2, 8'h2A, 1'b1); exp3_q.push_back(ew(1'b1, 2'd2, 8'h2A));
    wait_idle();
    push3(0, 8'h0A, 1'b1); push3(1, 8'h1A, 1'b1);
    exp3_q.push_back(ew(1'b1, 2'd0, 8'h0A));
    exp3_q.push_back(ew(1'b1, 2'd1, 8'h1A));
    wait_idle();
    push3(0, 8'h0B, 1'b1); push3(1, 8'h1B, 1'b1); push3(2, 8'h2B, 1'b1);
    exp3_q.push_back(ew(1'b1, 2'd2, 8'h2B));
    exp3_q.push_back(ew(1'b1, 2'd0, 8'h0B));
    exp3_q.push_back(ew(1'b1, 2'd1, 8'h1B));
    wait_idle();

`ifdef STREAM_ARB_PKT_EN
    // Packet lock: ptr=2, req0 3-beat packet; req3 arrives mid-packet and must wait.
    push4(0, 8'hE0, 1'b0); push4(0, 8'hE1, 1'b0); push4(0, 8'hE2, 1'b1);
    push4(1, 8'hF1, 1'b1);
    exp4_q.push_back(ew(1'b0, 2'd0, 8'hE0));
    exp4_q.push_back(ew(1'b0, 2'd0, 8'hE1));
    exp4_q.push_back(ew(1'b1, 2'd0, 8'hE2));
    exp4_q.push_back(ew(1'b1, 2'd1, 8'hF1));
    exp4_q.push_back(ew(1'b1, 2'd3, 8'hF3));
    wait_valid4();
    push4(3, 8'hF3, 1'b1);
    wait_idle();
`endif

    check("final_exp4_empty", exp4_q.size(), 0);
    check("final_exp3_empty", exp3_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
